// File: rtl/exe2mem_skid_reg_if.sv
// EXE->MEM stage boundary bundle: producer handshake, entry fields,
// flush, and the consumer side with the head entry and occupancy.
interface exe2mem_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // Producer (EXE) side
    logic              in_valid;
    logic              in_ready;
    logic              WB_EN_IN;
    logic              MEM_R_EN_IN;
    logic              MEM_W_EN_IN;
    logic [DATA_W-1:0] PCIn;
    logic [DATA_W-1:0] ALUResIn;
    logic [DATA_W-1:0] STValIn;
    logic [REG_W-1:0]  destIn;
    logic              flush;

    // Consumer (MEM) side
    logic              out_valid;
    logic              out_ready;
    logic              WB_EN;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [DATA_W-1:0] PC;
    logic [DATA_W-1:0] ALURes;
    logic [DATA_W-1:0] STVal;
    logic [REG_W-1:0]  dest;
    logic [1:0]        occupancy;

    // View taken by the pipeline register itself
    modport slave (
        input  in_valid, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
               PCIn, ALUResIn, STValIn, destIn, flush, out_ready,
        output in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN,
               PC, ALURes, STVal, dest, occupancy
    );

    // View taken by whatever drives and consumes the stage
    modport master (
        output in_valid, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
               PCIn, ALUResIn, STValIn, destIn, flush, out_ready,
        input  in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN,
               PC, ALURes, STVal, dest, occupancy
    );
endinterface

// File: rtl/exe2mem_skid_reg.sv
// EXE->MEM pipeline register with a 2-entry skid buffer (head + skid).
// in_ready is registered, so MEM back-pressure never reaches EXE through
// combinational logic. Supports a synchronous flush and optional
// suppression of write-back to register $zero.
module exe2mem_skid_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int DROP_R0 = 1
) (
    input  logic               clk,
    input  logic               rst,
    exe2mem_skid_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] st_val;
        logic [REG_W-1:0]  dest;
    } entry_t;

    state_t     state;
    entry_t     head;
    entry_t     skid;
    entry_t     in_entry;
    logic       in_ready_q;
    logic       out_valid_q;
    logic [1:0] occ_q;
    logic       in_fire;
    logic       out_fire;
    logic       wb_keep;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // A write to $zero is architecturally a no-op, so drop its WB enable here
    assign wb_keep = (DROP_R0 != 0) ? (bus.destIn != '0) : 1'b1;

    // Pack the incoming fields into one entry
    always_comb begin
        in_entry          = '0;
        in_entry.wb_en    = bus.WB_EN_IN & wb_keep;
        in_entry.mem_r_en = bus.MEM_R_EN_IN;
        in_entry.mem_w_en = bus.MEM_W_EN_IN;
        in_entry.pc       = bus.PCIn;
        in_entry.alu_res  = bus.ALUResIn;
        in_entry.st_val   = bus.STValIn;
        in_entry.dest     = bus.destIn;
    end

    // Occupancy FSM plus head/skid storage, with all handshake outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            // NOTE: the data registers are reset as well because their
            // value is visible on the outputs even while the stage is empty.
            head        <= '0;
            skid        <= '0;
        end else if (bus.flush) begin
            // Kill everything held; data fields keep their stale values
            state         <= EMPTY;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            occ_q         <= 2'd0;
            head.wb_en    <= 1'b0;
            head.mem_r_en <= 1'b0;
            head.mem_w_en <= 1'b0;
            skid.wb_en    <= 1'b0;
            skid.mem_r_en <= 1'b0;
            skid.mem_w_en <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the values that existed before this edge.
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        head        <= in_entry;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        occ_q       <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid       <= in_entry;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                        occ_q      <= 2'd2;
                    end else if (in_fire && out_fire) begin
                        head <= in_entry;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        occ_q       <= 2'd0;
                    end
                end
                FULL: begin
                    // in_ready is 0 here, so only a drain can happen
                    if (out_fire) begin
                        head       <= skid;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                        occ_q      <= 2'd1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    occ_q       <= 2'd0;
                end
            endcase
        end
    end

    // Control bits read as a bubble whenever no head entry is valid
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.occupancy = occ_q;
    assign bus.WB_EN     = head.wb_en    & out_valid_q;
    assign bus.MEM_R_EN  = head.mem_r_en & out_valid_q;
    assign bus.MEM_W_EN  = head.mem_w_en & out_valid_q;
    assign bus.PC        = head.pc;
    assign bus.ALURes    = head.alu_res;
    assign bus.STVal     = head.st_val;
    assign bus.dest      = head.dest;

endmodule

// File: tb/tb_exe2mem_skid_reg.sv
// Directed bench for exe2mem_skid_reg: reset, streaming, back-pressure,
// flush, $zero suppression (both DROP_R0 settings) and async reset.
module tb_exe2mem_skid_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    exe2mem_skid_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus0 ();
    exe2mem_skid_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus1 ();

    exe2mem_skid_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .DROP_R0(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    exe2mem_skid_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .DROP_R0(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // The DROP_R0=0 instance sees exactly the same stimulus
    assign bus1.in_valid    = bus0.in_valid;
    assign bus1.WB_EN_IN    = bus0.WB_EN_IN;
    assign bus1.MEM_R_EN_IN = bus0.MEM_R_EN_IN;
    assign bus1.MEM_W_EN_IN = bus0.MEM_W_EN_IN;
    assign bus1.PCIn        = bus0.PCIn;
    assign bus1.ALUResIn    = bus0.ALUResIn;
    assign bus1.STValIn     = bus0.STValIn;
    assign bus1.destIn      = bus0.destIn;
    assign bus1.flush       = bus0.flush;
    assign bus1.out_ready   = bus0.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                         input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] st, input logic [REG_W-1:0] d);
        bus0.in_valid    = v;
        bus0.WB_EN_IN    = wb;
        bus0.MEM_R_EN_IN = mr;
        bus0.MEM_W_EN_IN = mw;
        bus0.PCIn        = pc;
        bus0.ALUResIn    = alu;
        bus0.STValIn     = st;
        bus0.destIn      = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus0.flush     = 1'b0;
        bus0.out_ready = 1'b0;

        // ---------------- Reset with arbitrary inputs ----------------
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7);
        bus0.out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_in_ready",  bus0.in_ready,  1);
        check("rst_occupancy", bus0.occupancy, 0);
        check("rst_ctrl",      {bus0.WB_EN, bus0.MEM_R_EN, bus0.MEM_W_EN}, 0);
        check("rst_data",      {bus0.PC, bus0.ALURes}, 0);
        check("rst_st_dest",   {bus0.STVal, 27'd0, bus0.dest}, 0);

        idle();
        #2 rst = 1'b1;
        step();
        step();
        check("rel_out_valid", bus0.out_valid, 0);
        check("rel_in_ready",  bus0.in_ready,  1);
        check("rel_alu",       bus0.ALURes,    0);

        // ---------------- Streaming with out_ready=1 ----------------
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h400 + 32'(i * 4), 32'(16 * (i + 1)), 32'h0, 5'd2);
            step();
            check($sformatf("stream_valid_%0d", i), bus0.out_valid, 1);
            check($sformatf("stream_alu_%0d", i),   bus0.ALURes,    64'(16 * (i + 1)));
            check($sformatf("stream_rdy_%0d", i),   bus0.in_ready,  1);
            check($sformatf("stream_occ_%0d", i),   bus0.occupancy, 1);
        end
        idle();
        step();
        check("stream_drain_valid", bus0.out_valid, 0);
        check("stream_drain_wb",    bus0.WB_EN,     0);
        check("stream_hold_alu",    bus0.ALURes,    64'h40);

        // ---------------- Back-pressure ----------------
        bus0.out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h1, 32'h0, 5'd4);
        step();
        check("bp_pc0",  bus0.PC,        64'h100);
        check("bp_occ1", bus0.occupancy, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h2, 32'h0, 5'd5);
        step();
        check("bp_occ2",   bus0.occupancy, 2);
        check("bp_rdy0",   bus0.in_ready,  0);
        check("bp_pc_hd",  bus0.PC,        64'h100);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h108, 32'h3, 32'h0, 5'd6);
        step();
        check("bp_hold_occ", bus0.occupancy, 2);
        check("bp_hold_pc",  bus0.PC,        64'h100);
        bus0.out_ready = 1'b1;
        step();
        check("bp_pc1",    bus0.PC,        64'h104);
        check("bp_occ_dn", bus0.occupancy, 1);
        check("bp_rdy1",   bus0.in_ready,  1);
        step();
        check("bp_pc2",    bus0.PC,        64'h108);
        check("bp_occ_st", bus0.occupancy, 1);
        check("bp_dest2",  bus0.dest,      6);
        idle();
        step();
        check("bp_empty", bus0.out_valid, 0);

        // ---------------- Flush in FULL ----------------
        bus0.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'hA1, 32'h11, 5'd3);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h204, 32'hA2, 32'h22, 5'd3);
        step();
        check("fl_pre_occ", bus0.occupancy, 2);
        check("fl_pre_mw",  bus0.MEM_W_EN,  1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h208, 32'hDEAD, 32'h33, 5'd3);
        bus0.flush = 1'b1;
        step();
        check("fl_valid", bus0.out_valid, 0);
        check("fl_wb_mw", {bus0.WB_EN, bus0.MEM_W_EN}, 0);
        check("fl_occ",   bus0.occupancy, 0);
        check("fl_rdy",   bus0.in_ready,  1);
        check("fl_alu",   bus0.ALURes,    64'hA1);
        bus0.flush = 1'b0;
        idle();
        bus0.out_ready = 1'b1;
        step();
        check("fl_after_valid", bus0.out_valid, 0);
        check("fl_after_alu",   bus0.ALURes,    64'hA1);

        // Flush in ONE with a simultaneous accept: the accepted entry is lost
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'hB1, 32'h0, 5'd8);
        step();
        check("fl1_alu", bus0.ALURes, 64'hB1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h304, 32'hBEEF, 32'h0, 5'd8);
        bus0.flush = 1'b1;
        step();
        bus0.flush = 1'b0;
        idle();
        check("fl1_valid", bus0.out_valid, 0);
        check("fl1_alu",   bus0.ALURes,    64'hB1);
        step();
        check("fl1_stay_empty", bus0.occupancy, 0);

        // ---------------- $zero write suppression ----------------
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h50, 32'h0, 5'd0);
        step();
        check("r0_drop_wb",   bus0.WB_EN,    0);
        check("r0_drop_mr",   bus0.MEM_R_EN, 1);
        check("r0_keep_wb",   bus1.WB_EN,    1);
        check("r0_keep_mr",   bus1.MEM_R_EN, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h504, 32'h54, 32'h0, 5'd9);
        step();
        check("r9_wb", bus0.WB_EN, 1);
        check("r9_dest", bus0.dest, 9);
        idle();
        step();

        // ---------------- Async reset while FULL ----------------
        bus0.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h77, 32'h0, 5'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h604, 32'h78, 32'h0, 5'd1);
        step();
        idle();
        check("ar_pre_occ", bus0.occupancy, 2);
        #2 rst = 1'b0;
        #1;
        check("ar_valid", bus0.out_valid, 0);
        check("ar_rdy",   bus0.in_ready,  1);
        check("ar_occ",   bus0.occupancy, 0);
        check("ar_alu",   bus0.ALURes,    0);
        #1 rst = 1'b1;
        bus0.out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h55, 32'h0, 5'd1);
        step();
        check("ar_first_valid", bus0.out_valid, 1);
        check("ar_first_alu",   bus0.ALURes,    64'h55);
        check("ar_first_occ",   bus0.occupancy, 1);
        idle();
        step();
        check("ar_drain", bus0.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
